// File: rtl/cdc_pkg.sv
// Shared constants for the clock-domain-crossing blocks.
package cdc_pkg;

  localparam int DEF_BUS_WIDTH   = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MAX_SYNC_STAGES = 4;

endpackage : cdc_pkg

// File: rtl/bit_sync.sv
// Single-bit synchroniser: NUM_STAGES flop chain into the clk domain.
module bit_sync
  import cdc_pkg::*;
#(
  parameter int NUM_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (NUM_STAGES < MIN_SYNC_STAGES || NUM_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("bit_sync: NUM_STAGES must be in %0d..%0d", MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  logic [NUM_STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its predecessor held before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= '0;
    else      chain <= {chain[NUM_STAGES-2:0], d};
  end

  assign q = chain[NUM_STAGES-1];

endmodule : bit_sync

// File: rtl/data_sync.sv
// Multi-bit CDC receiver: synchronised enable edge captures a stable bus
// into a holding register offered to the consumer with a valid/ready handshake.
module data_sync
  import cdc_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int NUM_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  input  logic                 sync_ready,
  input  logic                 clr_overrun,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 sync_valid,
  output logic                 enable_pulse,
  output logic                 overrun
);

  if (NUM_STAGES < MIN_SYNC_STAGES || NUM_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("data_sync: NUM_STAGES must be in %0d..%0d", MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end

  logic en_sync;
  logic en_q;
  logic rise;
  logic capture;
  logic drop;

  bit_sync #(.NUM_STAGES(NUM_STAGES)) u_enable_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus_enable),
    .q   (en_sync)
  );

  assign rise    = en_sync & ~en_q;
  // A consumer accepting in the same cycle frees the register for the new word.
  assign capture = rise & (~sync_valid | sync_ready);
  assign drop    = rise & sync_valid & ~sync_ready;

  // NOTE: the data register is reset along with the control flops so the
  // consumer never sees an undefined bus after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q         <= 1'b0;
      sync_bus     <= '0;
      sync_valid   <= 1'b0;
      enable_pulse <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      en_q         <= en_sync;
      enable_pulse <= capture;

      if (capture) sync_bus <= unsync_bus;

      if (capture)                       sync_valid <= 1'b1;
      else if (sync_valid && sync_ready) sync_valid <= 1'b0;

      // Setting has priority so a collision with a clear never loses an overrun.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule : data_sync

// File: tb/tb_data_sync.sv
// Directed self-checking bench for data_sync (BUS_WIDTH=8, NUM_STAGES=2).
module tb_data_sync;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable;
  logic          sync_ready;
  logic          clr_overrun;
  logic [BW-1:0] sync_bus;
  logic          sync_valid;
  logic          enable_pulse;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  data_sync #(.BUS_WIDTH(BW), .NUM_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .unsync_bus   (unsync_bus),
    .bus_enable   (bus_enable),
    .sync_ready   (sync_ready),
    .clr_overrun  (clr_overrun),
    .sync_bus     (sync_bus),
    .sync_valid   (sync_valid),
    .enable_pulse (enable_pulse),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; unsync_bus = '0; bus_enable = 1'b0; sync_ready = 1'b0; clr_overrun = 1'b0;
    tick(2);
    checks++;
    if ({sync_bus, sync_valid, enable_pulse, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bus=%h v=%b p=%b o=%b, want all 0",
               sync_bus, sync_valid, enable_pulse, overrun);
    end
    rst = 1'b1;
    tick(3);
    checks++;
    if ({sync_valid, enable_pulse, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got v=%b p=%b o=%b, want 000", sync_valid, enable_pulse, overrun);
    end
  endtask

  task automatic test_basic();
    sync_ready = 1'b1; unsync_bus = 8'hA5; bus_enable = 1'b1;
    tick(2);                                  // edges 0,1: nothing yet
    checks++;
    if (enable_pulse !== 1'b0 || sync_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: got p=%b v=%b, want 0 0", enable_pulse, sync_valid);
    end
    tick();                                   // edge 2: capture
    checks++;
    if (enable_pulse !== 1'b1 || sync_valid !== 1'b1 || sync_bus !== 8'hA5) begin
      errors++;
      $display("FAIL basic_capture: got p=%b v=%b bus=%h, want 1 1 a5", enable_pulse, sync_valid, sync_bus);
    end
    tick();
    checks++;
    if (enable_pulse !== 1'b0 || sync_valid !== 1'b0 || overrun !== 1'b0 || sync_bus !== 8'hA5) begin
      errors++;
      $display("FAIL basic_after: got p=%b v=%b o=%b bus=%h, want 0 0 0 a5",
               enable_pulse, sync_valid, overrun, sync_bus);
    end
    tick(2);
    bus_enable = 1'b0;
    tick(5);
    sync_ready = 1'b0;
  endtask

  task automatic test_held_consumer();
    unsync_bus = 8'h3C; bus_enable = 1'b1;
    tick(5);
    bus_enable = 1'b0;
    tick(5);
    checks++;
    if (sync_valid !== 1'b1 || sync_bus !== 8'h3C || enable_pulse !== 1'b0) begin
      errors++;
      $display("FAIL held_wait: got v=%b bus=%h p=%b, want 1 3c 0", sync_valid, sync_bus, enable_pulse);
    end
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
    checks++;
    if (sync_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_release: got v=%b, want 0", sync_valid);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    unsync_bus = 8'h11; bus_enable = 1'b1;
    tick(5);
    bus_enable = 1'b0;
    tick(5);
    unsync_bus = 8'h22; bus_enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (enable_pulse) pulses++;
    end
    bus_enable = 1'b0;
    tick(5);
    checks++;
    if (overrun !== 1'b1 || sync_bus !== 8'h11 || sync_valid !== 1'b1 || pulses != 0) begin
      errors++;
      $display("FAIL overrun_set: got o=%b bus=%h v=%b pulses=%0d, want 1 11 1 0",
               overrun, sync_bus, sync_valid, pulses);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0 || sync_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear: got o=%b v=%b, want 0 1", overrun, sync_valid);
    end
  endtask

  task automatic test_back_to_back();
    sync_ready = 1'b1;                        // drain 0x11
    tick();
    sync_ready = 1'b0;
    unsync_bus = 8'h44; bus_enable = 1'b1;
    tick(5);
    bus_enable = 1'b0;
    tick(5);
    checks++;
    if (sync_valid !== 1'b1 || sync_bus !== 8'h44) begin
      errors++;
      $display("FAIL b2b_first: got v=%b bus=%h, want 1 44", sync_valid, sync_bus);
    end
    unsync_bus = 8'h55; bus_enable = 1'b1;
    tick(2);
    sync_ready = 1'b1;                        // ready during the edge-detect cycle
    tick();
    sync_ready = 1'b0;
    checks++;
    if (sync_bus !== 8'h55 || sync_valid !== 1'b1 || enable_pulse !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got bus=%h v=%b p=%b o=%b, want 55 1 1 0",
               sync_bus, sync_valid, enable_pulse, overrun);
    end
    tick(2);
    bus_enable = 1'b0;
    tick(5);
  endtask

  task automatic test_collision();
    unsync_bus = 8'h66; bus_enable = 1'b1;
    tick(2);
    clr_overrun = 1'b1;                       // clear coincides with the dropping edge
    tick();
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1 || sync_bus !== 8'h55 || enable_pulse !== 1'b0) begin
      errors++;
      $display("FAIL collision_set_wins: got o=%b bus=%h p=%b, want 1 55 0", overrun, sync_bus, enable_pulse);
    end
    tick(2);
    bus_enable = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    tick(4);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: got o=%b, want 0", overrun);
    end
    sync_ready = 1'b1;
    tick();
    sync_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    unsync_bus = 8'h7E; bus_enable = 1'b1;
    tick();                                   // edge 0 samples the enable
    rst = 1'b0;
    #1;
    checks++;
    if ({sync_bus, sync_valid, enable_pulse, overrun} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got bus=%h v=%b p=%b o=%b, want all 0",
               sync_bus, sync_valid, enable_pulse, overrun);
    end
    tick(3);
    checks++;
    if ({sync_bus, sync_valid, enable_pulse, overrun} !== '0) begin
      errors++;
      $display("FAIL midreset_held: got bus=%h v=%b p=%b o=%b, want all 0",
               sync_bus, sync_valid, enable_pulse, overrun);
    end
    rst = 1'b1;
    tick(2);
    checks++;
    if (enable_pulse !== 1'b0 || sync_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_early: got p=%b v=%b, want 0 0", enable_pulse, sync_valid);
    end
    tick();
    checks++;
    if (enable_pulse !== 1'b1 || sync_valid !== 1'b1 || sync_bus !== 8'h7E) begin
      errors++;
      $display("FAIL midreset_capture: got p=%b v=%b bus=%h, want 1 1 7e", enable_pulse, sync_valid, sync_bus);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (enable_pulse) pulses++;
    end
    checks++;
    if (pulses != 0 || sync_bus !== 8'h7E) begin
      errors++;
      $display("FAIL midreset_single: got extra pulses=%0d bus=%h, want 0 7e", pulses, sync_bus);
    end
    bus_enable = 1'b0;
    tick(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held_consumer();
    test_overrun();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_sync
